// File: rtl/multicycle_datapath.sv
// multicycle_datapath: one-instruction-at-a-time decode/execute/memory/writeback core
// with its own register file, data memory and ALU behind a valid/ready handshake.
module multicycle_datapath #(
    parameter int WIDTH     = 32,
    parameter int REG_COUNT = 32,
    parameter int DM_DEPTH  = 256
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             instr_valid_i,
    input  logic [31:0]      instruction_i,
    output logic             instr_ready_o,
    output logic [WIDTH-1:0] dp_out_o,
    output logic             done_o,
    output logic             illegal_o,
    output logic [15:0]      retire_count_o
);
    localparam int AW = $clog2(DM_DEPTH);
    localparam logic [5:0] OP_NOP = 6'h00, OP_ADD = 6'h01, OP_ADDI = 6'h02,
                           OP_LOAD = 6'h03, OP_LOADI = 6'h04, OP_STORE = 6'h05;

    typedef enum logic [2:0] {IDLE, DECODE, EXECUTE, MEMORY, WRITEBACK} state_t;

    state_t           state_q, state_d;
    logic [31:0]      instr_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, dp_out_q;
    logic             done_q, illegal_q;
    logic [15:0]      cnt_q;
    logic [WIDTH-1:0] rf_q [REG_COUNT];
    logic [WIDTH-1:0] dm_q [DM_DEPTH];

    logic [5:0]       opc;
    logic [4:0]       op1, op2, op3, dst;
    logic [15:0]      imm;
    logic [AW-1:0]    addr;
    logic             legal, accept, dm_we, rf_we;
    logic [WIDTH-1:0] ra, rb;

    assign opc  = instr_q[31:26];
    assign op1  = instr_q[25:21];
    assign op2  = instr_q[20:16];
    assign op3  = instr_q[15:11];
    assign imm  = instr_q[15:0];
    assign addr = instr_q[AW-1:0];
    assign legal = opc <= OP_STORE;
    // R0 and indices beyond the register file read as zero
    assign ra = (op1 != 5'd0 && int'(op1) < REG_COUNT) ? rf_q[op1] : '0;
    assign rb = (op2 != 5'd0 && int'(op2) < REG_COUNT) ? rf_q[op2] : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = instr_valid_i ? DECODE : IDLE;
            DECODE:    state_d = (opc == OP_ADD || opc == OP_ADDI || opc == OP_LOADI) ? EXECUTE :
                                 (opc == OP_LOAD || opc == OP_STORE) ? MEMORY : WRITEBACK;
            EXECUTE:   state_d = WRITEBACK;
            MEMORY:    state_d = WRITEBACK;
            WRITEBACK: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_ready_o = state_q == IDLE;
        accept = instr_ready_o && instr_valid_i;
        dm_we  = state_q == MEMORY && opc == OP_STORE;
        dst    = opc == OP_ADD ? op3 : opc == OP_ADDI ? op2 : op1;
        rf_we  = state_q == WRITEBACK && (opc == OP_ADD || opc == OP_ADDI || opc == OP_LOADI ||
                 opc == OP_LOAD) && dst != 5'd0 && int'(dst) < REG_COUNT;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            dp_out_q  <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= state_q == WRITEBACK;
            illegal_q <= state_q == WRITEBACK && !legal;
            if (accept) instr_q <= instruction_i;
            if (state_q == DECODE) begin
                a_q <= ra;
                b_q <= opc == OP_ADD ? rb : opc == OP_ADDI ? WIDTH'(signed'(imm)) : WIDTH'(imm);
            end
            if (state_q == EXECUTE) res_q <= opc == OP_LOADI ? b_q : a_q + b_q;
            if (state_q == MEMORY) res_q <= opc == OP_STORE ? a_q : dm_q[addr];
            if (state_q == WRITEBACK && legal) begin
                cnt_q <= cnt_q + 16'd1;
                if (opc != OP_NOP) dp_out_q <= res_q;
            end
            if (rf_we) rf_q[dst] <= res_q;
        end
    end

    // Data memory keeps its contents across reset; only the write is gated
    always_ff @(posedge clock_i) begin
        if (reset_n_i && dm_we) dm_q[addr] <= a_q;
    end

    assign dp_out_o       = dp_out_q;
    assign done_o         = done_q;
    assign illegal_o      = illegal_q;
    assign retire_count_o = cnt_q;
endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: directed checks of the multicycle datapath with hand-computed results.
module tb_multicycle_datapath;
    logic        clock_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        instr_valid_i = 1'b0;
    logic [31:0] instruction_i = '0;
    logic        instr_ready_o, done_o, illegal_o;
    logic [31:0] dp_out_o;
    logic [15:0] retire_count_o;
    int checks = 0;
    int errors = 0;

    multicycle_datapath dut (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .instr_valid_i(instr_valid_i),
        .instruction_i(instruction_i), .instr_ready_o(instr_ready_o), .dp_out_o(dp_out_o),
        .done_o(done_o), .illegal_o(illegal_o), .retire_count_o(retire_count_o)
    );

    always #5 clock_i = ~clock_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] ins(input logic [5:0] o, input logic [4:0] a, input logic [4:0] b,
                                        input logic [15:0] imm);
        return {o, a, b, imm};
    endfunction

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic accept(input logic [31:0] i);
        int n = 0;
        while (!instr_ready_o && n < 20) begin tick(); n++; end
        checks++;
        if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL ready_wait: ready=%b required 1", instr_ready_o); end
        instruction_i = i;
        instr_valid_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        instruction_i = $urandom;
    endtask

    task automatic exec(input logic [31:0] i, output int lat);
        accept(i);
        lat = 0;
        while (!done_o && lat < 10) begin tick(); lat++; end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        tick(); tick();
        checks += 5;
        if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", instr_ready_o); end
        if (dp_out_o !== 32'd0) begin errors++; $display("FAIL reset_dp: got %h required 0", dp_out_o); end
        if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done_o); end
        if (illegal_o !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b required 0", illegal_o); end
        if (retire_count_o !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", retire_count_o); end
        reset_n_i = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        int lat;
        exec(ins(6'h04, 5'd1, 5'd0, 16'd5), lat);
        checks += 2;
        if (lat !== 3) begin errors++; $display("FAIL loadi_latency: got %0d required 3", lat); end
        if (dp_out_o !== 32'd5) begin errors++; $display("FAIL loadi_r1: got %h required 5", dp_out_o); end
        exec(ins(6'h04, 5'd2, 5'd0, 16'd7), lat);
        checks++;
        if (dp_out_o !== 32'd7) begin errors++; $display("FAIL loadi_r2: got %h required 7", dp_out_o); end
        exec(ins(6'h01, 5'd1, 5'd2, {5'd3, 11'd0}), lat);
        checks += 4;
        if (lat !== 3) begin errors++; $display("FAIL add_latency: got %0d required 3", lat); end
        if (dp_out_o !== 32'd12) begin errors++; $display("FAIL add_r3: got %h required c", dp_out_o); end
        if (illegal_o !== 1'b0) begin errors++; $display("FAIL add_illegal: got %b required 0", illegal_o); end
        if (retire_count_o !== 16'd3) begin errors++; $display("FAIL add_count: got %0d required 3", retire_count_o); end
    endtask

    task automatic test_addi();
        int lat;
        exec(ins(6'h02, 5'd3, 5'd4, 16'hFFFF), lat);
        checks++;
        if (dp_out_o !== 32'd11) begin errors++; $display("FAIL addi_neg: got %h required b", dp_out_o); end
        exec(ins(6'h02, 5'd0, 5'd5, 16'hFFFF), lat);
        checks++;
        if (dp_out_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_sext: got %h required ffffffff", dp_out_o); end
        exec(ins(6'h01, 5'd5, 5'd5, {5'd6, 11'd0}), lat);
        checks++;
        if (dp_out_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL add_wrap: got %h required fffffffe", dp_out_o); end
    endtask

    task automatic test_memory();
        int lat;
        exec(ins(6'h05, 5'd3, 5'd0, 16'h0010), lat);
        checks += 2;
        if (lat !== 3) begin errors++; $display("FAIL store_latency: got %0d required 3", lat); end
        if (dp_out_o !== 32'd12) begin errors++; $display("FAIL store_dp: got %h required c", dp_out_o); end
        exec(ins(6'h04, 5'd3, 5'd0, 16'd0), lat);
        exec(ins(6'h03, 5'd7, 5'd0, 16'h0010), lat);
        checks += 2;
        if (lat !== 3) begin errors++; $display("FAIL load_latency: got %0d required 3", lat); end
        if (dp_out_o !== 32'd12) begin errors++; $display("FAIL load_r7: got %h required c", dp_out_o); end
        exec(ins(6'h01, 5'd7, 5'd0, {5'd8, 11'd0}), lat);
        checks++;
        if (dp_out_o !== 32'd12) begin errors++; $display("FAIL add_r8: got %h required c", dp_out_o); end
        exec(ins(6'h01, 5'd3, 5'd0, {5'd9, 11'd0}), lat);
        checks += 2;
        if (dp_out_o !== 32'd0) begin errors++; $display("FAIL r3_cleared: got %h required 0", dp_out_o); end
        if (retire_count_o !== 16'd11) begin errors++; $display("FAIL mem_count: got %0d required 11", retire_count_o); end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int dn = 0;
        logic [31:0] dp3 = '0, dp7 = '0;
        instruction_i = ins(6'h04, 5'd0, 5'd0, 16'd9);
        instr_valid_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (instr_ready_o) acc++;
            tick();
            if (k == 0) instruction_i = ins(6'h01, 5'd0, 5'd0, {5'd1, 11'd0});
            if (done_o) dn++;
            if (k == 3) dp3 = dp_out_o;
            if (k == 7) dp7 = dp_out_o;
        end
        instr_valid_i = 1'b0;
        checks += 5;
        if (acc !== 2) begin errors++; $display("FAIL b2b_accepts: got %0d required 2", acc); end
        if (dn !== 2) begin errors++; $display("FAIL b2b_done: got %0d required 2", dn); end
        if (dp3 !== 32'd9) begin errors++; $display("FAIL r0_write_dp: got %h required 9", dp3); end
        if (dp7 !== 32'd0) begin errors++; $display("FAIL r0_reads_zero: got %h required 0", dp7); end
        if (retire_count_o !== 16'd13) begin errors++; $display("FAIL b2b_count: got %0d required 13", retire_count_o); end
    endtask

    task automatic test_illegal();
        int lat;
        exec(ins(6'h04, 5'd10, 5'd0, 16'h1234), lat);
        exec(ins(6'h3F, 5'd1, 5'd2, 16'hFFFF), lat);
        checks += 5;
        if (lat !== 2) begin errors++; $display("FAIL illegal_latency: got %0d required 2", lat); end
        if (illegal_o !== 1'b1) begin errors++; $display("FAIL illegal_pulse: got %b required 1", illegal_o); end
        if (dp_out_o !== 32'h1234) begin errors++; $display("FAIL illegal_dp: got %h required 1234", dp_out_o); end
        if (retire_count_o !== 16'd14) begin errors++; $display("FAIL illegal_count: got %0d required 14", retire_count_o); end
        if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL illegal_ready: got %b required 1", instr_ready_o); end
        tick();
        checks += 3;
        if (done_o !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b required 0", done_o); end
        if (illegal_o !== 1'b0) begin errors++; $display("FAIL illegal_one_cycle: got %b required 0", illegal_o); end
        if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL illegal_ready_t3: got %b required 1", instr_ready_o); end
        exec(ins(6'h00, 5'd1, 5'd2, 16'h5555), lat);
        checks += 4;
        if (lat !== 2) begin errors++; $display("FAIL nop_latency: got %0d required 2", lat); end
        if (illegal_o !== 1'b0) begin errors++; $display("FAIL nop_illegal: got %b required 0", illegal_o); end
        if (dp_out_o !== 32'h1234) begin errors++; $display("FAIL nop_dp: got %h required 1234", dp_out_o); end
        if (retire_count_o !== 16'd15) begin errors++; $display("FAIL nop_count: got %0d required 15", retire_count_o); end
    endtask

    task automatic test_reset_abort();
        int lat;
        int dn = 0;
        exec(ins(6'h04, 5'd1, 5'd0, 16'd5), lat);
        exec(ins(6'h04, 5'd2, 5'd0, 16'd7), lat);
        accept(ins(6'h01, 5'd1, 5'd2, {5'd3, 11'd0}));
        tick();
        reset_n_i = 1'b0;
        tick();
        reset_n_i = 1'b1;
        checks += 3;
        if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b required 1", instr_ready_o); end
        if (dp_out_o !== 32'd0) begin errors++; $display("FAIL abort_dp: got %h required 0", dp_out_o); end
        if (retire_count_o !== 16'd0) begin errors++; $display("FAIL abort_count: got %0d required 0", retire_count_o); end
        for (int k = 0; k < 5; k++) begin
            if (done_o) dn++;
            tick();
        end
        checks++;
        if (dn !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses required 0", dn); end
        exec(ins(6'h01, 5'd3, 5'd0, {5'd11, 11'd0}), lat);
        checks += 2;
        if (dp_out_o !== 32'd0) begin errors++; $display("FAIL abort_r3: got %h required 0", dp_out_o); end
        if (retire_count_o !== 16'd1) begin errors++; $display("FAIL abort_recount: got %0d required 1", retire_count_o); end
    endtask

    task automatic test_store_abort();
        int lat;
        exec(ins(6'h04, 5'd1, 5'd0, 16'h0055), lat);
        exec(ins(6'h05, 5'd1, 5'd0, 16'h0020), lat);
        exec(ins(6'h04, 5'd1, 5'd0, 16'h00AA), lat);
        accept(ins(6'h05, 5'd1, 5'd0, 16'h0020));
        tick();
        reset_n_i = 1'b0;
        tick();
        reset_n_i = 1'b1;
        exec(ins(6'h03, 5'd2, 5'd0, 16'h0020), lat);
        checks += 2;
        if (dp_out_o !== 32'h55) begin errors++; $display("FAIL store_suppressed: got %h required 55", dp_out_o); end
        if (retire_count_o !== 16'd1) begin errors++; $display("FAIL store_abort_count: got %0d required 1", retire_count_o); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_addi();
        test_memory();
        test_back_to_back();
        test_illegal();
        test_reset_abort();
        test_store_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Parametrised multi-cycle datapath that executes one instruction at a time through a decode/execute/memory/writeback state machine. It owns its register file, data memory and ALU. It accepts instructions over a valid/ready handshake and reports each retired result with a one-cycle done pulse. It is the next-generation core datapath: width and storage sizes are generalised, and it adds handshaking, illegal-opcode detection, a retire counter and reset behaviour.

## Interface
- WIDTH, 32, data path / register / memory word width (≥16)
- REG_COUNT, 32, architectural registers (2..32); R0 reads zero
- DM_DEPTH, 256, data memory words (power of 2, ≤256)
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- instr_valid  in  1  instruction present on `instruction`
- instruction  in  32  opcode[31:26], op1[25:21], op2[20:16], op3[15:11], imm[15:0], dm_addr[7:0]
- instr_ready  out  1  high exactly when state is IDLE
- dp_out  out  WIDTH  result of last retired instruction (registered)
- done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse when an unknown opcode retires
- retire_count  out  16  count of legally retired instructions, wraps 0xFFFF→0

## Operation
- Clock is `clock`; reset is synchronous and active-low on `reset_n`.
- Opcodes: NOP=6'h00, ADD=6'h01, ADDI=6'h02, LOAD=6'h03, LOADI=6'h04, STORE=6'h05; all others are illegal.
- ADD: R[op3] = R[op1] + R[op2].
- ADDI: R[op2] = R[op1] + sign-extended imm.
- LOADI: R[op1] = zero-extended imm.
- LOAD: R[op1] = DM[dm_addr].
- STORE: DM[dm_addr] = R[op1]; dp_out = stored value.
- NOP: dp_out unchanged; done pulses.
- Arithmetic is modulo 2^WIDTH; carry is discarded; no flags.
- dm_addr uses the low log2(DM_DEPTH) bits.
- Writes to R0, or to an index ≥ REG_COUNT, are dropped. Reads of those indices return 0. dp_out still shows the computed value.
- Instruction fields are latched at acceptance; `instruction` may change afterwards.
- FSM states: IDLE, DECODE, EXECUTE, MEMORY, WRITEBACK.
  - IDLE→DECODE when instr_valid && instr_ready.
  - DECODE latches operands, then branches by opcode:
    - ADD/ADDI/LOADI → EXECUTE
    - LOAD/STORE → MEMORY
    - NOP/illegal → WRITEBACK
  - EXECUTE→WRITEBACK.
  - MEMORY→WRITEBACK. STORE writes DM in MEMORY; LOAD reads DM in MEMORY.
  - WRITEBACK commits the register write, updates dp_out, pulses done (plus illegal if illegal), then →IDLE.
- Illegal opcode: no register or memory change, dp_out unchanged, retire_count unchanged.
- Reset values: state IDLE, instr_ready 1, dp_out 0, done 0, illegal 0, retire_count 0, all registers 0. DM contents are not reset.

## Timing
- Acceptance edge = T0.
  - ALU ops: done at T0+3 (DECODE at T0+1, EXECUTE at T0+2, WRITEBACK at T0+3).
  - LOAD/STORE: done at T0+3.
  - NOP/illegal: done at T0+2.
- instr_ready drops at T0+1 and returns the cycle after WRITEBACK. Back-to-back ALU instructions are therefore accepted every 4 cycles.
- Register write, dp_out and retire_count update on the WRITEBACK edge. An instruction accepted next sees the new value.
- instr_valid while busy is ignored; the source holds it until ready.
- reset_n low in any state aborts the instruction: no register, DM or counter commit on that edge; outputs take reset values the next cycle.
- reset_n low concurrent with a STORE in MEMORY: the DM write is suppressed.
- retire_count increments by 1 per legal WRITEBACK (NOP included).

## Test plan
- Reset, then LOADI r1,5; LOADI r2,7; ADD r3=r1+r2 → dp_out=12, done 3 cycles after the ADD acceptance, retire_count=3.
- With r3=12: ADDI r4=r3+16'hFFFF → dp_out=11. ADDI r5=r0+16'hFFFF, then ADD r6=r5+r5 → 0xFFFFFFFE (carry dropped).
- STORE r3 to dm_addr 8'h10; LOADI r3,0; LOAD r7 from 8'h10 → dp_out=12, r3 reads 0. Data is also observed via ADD r8=r7+r0 = 12.
- LOADI r0,9, then ADD r1=r0+r0 → r0 stays 0, result 0; instr_valid held high throughout with exactly one acceptance per 4 cycles.
- Opcode 6'h3F → illegal and done pulse at T0+2, dp_out and retire_count unchanged, instr_ready 1 at T0+3.
- ADD r3=r1+r2 with reset_n pulsed low during EXECUTE → no done, r3=0, dp_out=0, instr_ready=1 the cycle after reset_n rises.
